// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// uart_pkt_pkg: shared state/error encodings for the UART packet controller
package uart_pkt_pkg;
  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, HOLD} pkt_state_t;
  typedef enum logic [2:0] {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT, ERR_OVERRUN} pkt_err_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_rx_pkt_ctrl_if.sv
// uart_pkt_if: pop-style read port for buffered packets
interface uart_pkt_if #(parameter int LEN_W = 5);
  logic             pkt_valid;
  logic [LEN_W-1:0] pkt_len;
  logic [7:0]       byte_data;
  logic             byte_rd;
  modport master (output pkt_valid, pkt_len, byte_data, input byte_rd);
  modport slave (input pkt_valid, pkt_len, byte_data, output byte_rd);
endinterface

// File: rtl/uart_rx_pkt_ctrl_timeout.sv
// uart_pkt_timeout: inter-byte watchdog, pulses expire after TIMEOUT_CYCLES quiet cycles
module uart_pkt_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timer_q;
  assign expire_o = en_i && !clear_i && timer_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    timer_q <= (rst || clear_i || !en_i || expire_o) ? '0 : timer_q + 1'b1;
endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: frames UART bytes into sync/len/payload/checksum packets
module uart_rx_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_enable,
  output logic       rx_enable,
  input  logic [7:0] rx_data,
  input  logic       rx_data_ready,
  input  logic       rx_busy,
  uart_pkt_if.master pkt,
  output logic       err_pulse,
  output logic [2:0] err_code,
  output logic [7:0] err_count,
  output logic       busy
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  pkt_state_t state_q, state_d;
  pkt_err_t err_d;
  logic [LEN_W-1:0] len_q, len_d, wr_q, wr_d, rd_q, rd_d;
  logic [7:0] csum_q, csum_d, err_count_q;
  logic [2:0] err_code_q;
  logic rdy_q, valid_q, valid_d, rx_en_q, err_pulse_q;
  logic ev, sync_ev, in_pkt, last_rd, expire, we, unused_rx_busy;
  logic [7:0] buf_q [MAX_LEN];
  assign unused_rx_busy = rx_busy;
  assign ev = rx_data_ready && !rdy_q;
  assign sync_ev = ev && ctrl_enable && rx_data == SYNC_BYTE;
  assign in_pkt = state_q inside {LEN, PAYLOAD, CSUM};
  assign last_rd = pkt.byte_rd && rd_q == len_q - 1'b1;
  uart_pkt_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst(rst), .clear_i(ev), .en_i(in_pkt), .expire_o(expire)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    wr_d = wr_q;
    rd_d = rd_q;
    csum_d = csum_q;
    valid_d = valid_q;
    err_d = ERR_NONE;
    we = 1'b0;
    if (in_pkt && !ctrl_enable) state_d = HUNT;
    else if (expire) begin
      state_d = HUNT;
      err_d = ERR_TIMEOUT;
    end else case (state_q)
      HUNT: state_d = sync_ev ? LEN : HUNT;
      LEN: if (ev) begin
        if (rx_data != 8'd0 && int'(rx_data) <= MAX_LEN) begin
          len_d = rx_data[LEN_W-1:0];
          wr_d = '0;
          csum_d = '0;
          state_d = PAYLOAD;
        end else begin
          state_d = HUNT;
          err_d = ERR_LEN;
        end
      end
      PAYLOAD: if (ev) begin
        we = 1'b1;
        csum_d = csum_q + rx_data;
        wr_d = wr_q + 1'b1;
        state_d = wr_q == len_q - 1'b1 ? CSUM : PAYLOAD;
      end
      CSUM: if (ev) begin
        state_d = rx_data == csum_q ? HOLD : HUNT;
        valid_d = rx_data == csum_q;
        rd_d = '0;
        err_d = rx_data == csum_q ? ERR_NONE : ERR_CSUM;
      end
      HOLD: if (last_rd) begin
        // Releasing the buffer takes priority; the same byte may start the next packet.
        valid_d = 1'b0;
        state_d = sync_ev ? LEN : HUNT;
      end else begin
        rd_d = pkt.byte_rd ? rd_q + 1'b1 : rd_q;
        err_d = ev ? ERR_OVERRUN : ERR_NONE;
      end
      default: state_d = HUNT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      len_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      csum_q <= '0;
      valid_q <= 1'b0;
      rdy_q <= 1'b0;
      rx_en_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      csum_q <= csum_d;
      valid_q <= valid_d;
      rdy_q <= rx_data_ready;
      rx_en_q <= ctrl_enable;
      err_pulse_q <= err_d != ERR_NONE;
      if (err_d != ERR_NONE) begin
        err_code_q <= err_d;
        err_count_q <= err_count_q == 8'hFF ? err_count_q : err_count_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (we) buf_q[wr_q[AW-1:0]] <= rx_data;
  assign rx_enable = rx_en_q;
  assign pkt.pkt_valid = valid_q;
  assign pkt.pkt_len = len_q;
  assign pkt.byte_data = buf_q[rd_q[AW-1:0]];
  assign err_pulse = err_pulse_q;
  assign err_code = err_code_q;
  assign err_count = err_count_q;
  assign busy = in_pkt;
endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
Controller that sequences the on-chip UART receiver and turns its raw byte stream into validated packets. It enables and monitors the receiver, hunts for a sync byte, then collects length, payload and checksum. Good packets are buffered for a downstream consumer through a pop-style read handshake. Framing, length, checksum, timeout and overrun errors are counted and flagged.

Parameters:
MAX_LEN, 16, maximum payload bytes per packet (1..255)
SYNC_BYTE, 8'hA5, packet start marker
TIMEOUT_CYCLES, 1000, max clk cycles between bytes inside a packet before abort
LEN_W, $clog2(MAX_LEN+1), width of length/pointer fields (derived)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
ctrl_enable  input  1  software enable for reception
rx_enable  output  1  enable to UART receiver
rx_data  input  8  receiver data_out
rx_data_ready  input  1  receiver byte-complete flag
rx_busy  input  1  receiver "receiving" flag; status only
pkt_valid  output  1  complete good packet held in buffer
pkt_len  output  LEN_W  payload length of held packet
byte_data  output  8  current payload byte (buf[rd_ptr])
byte_rd  input  1  pop current byte; ignored when pkt_valid=0
err_pulse  output  1  one-cycle pulse on any error
err_code  output  3  last error: 0 none, 1 bad length, 2 bad checksum, 3 timeout, 4 overrun
err_count  output  8  saturating error count
busy  output  1  state not HUNT/HOLD

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: rx_enable=0, pkt_valid=0, pkt_len=0, byte_data=buf[0], err_pulse=0, err_code=0, err_count=0, busy=0, state=HUNT, rd_ptr=0, wr_ptr=0, csum=0, timer=0.
- rx_enable is registered. It equals ctrl_enable one cycle later; rst forces it to 0.
- Byte event: rx_data_ready=1 while the registered previous value is 0. rx_data is sampled in that cycle. Only a rising edge counts, so a level held high yields exactly one event.
- States:
  - HUNT: on an event with data==SYNC_BYTE, go to LEN. Other bytes are silently discarded (no error).
  - LEN: on an event with data in 1..MAX_LEN, set pkt_len=data, clear wr_ptr and csum, go to PAYLOAD. A value of 0 or >MAX_LEN raises error 1 and goes to HUNT.
  - PAYLOAD: on each event, write buf[wr_ptr]=data, add data to csum mod 256, increment wr_ptr. After the pkt_len-th byte, go to CSUM.
  - CSUM: on an event, if data==csum go to HOLD and set pkt_valid=1 with rd_ptr=0. Otherwise raise error 2 and go to HUNT.
  - HOLD: byte_rd advances rd_ptr. A byte_rd while rd_ptr==pkt_len-1 clears pkt_valid and goes to HUNT.
- Latency: pkt_valid rises the cycle after the checksum event. byte_data reflects the new rd_ptr the cycle after byte_rd.
- Timeout: timer resets on every event and counts in LEN, PAYLOAD and CSUM. When timer==TIMEOUT_CYCLES-1 with no event, raise error 3 and go to HUNT. The timer is idle in HUNT and HOLD.
- Overrun: an event in HOLD raises error 4 and drops the byte. pkt_valid and the buffer are unaffected.
- Simultaneous final byte_rd and event in HOLD: the release wins. The byte is then evaluated as in HUNT (SYNC goes to LEN), and no overrun is raised.
- Errors: err_pulse is high for one cycle. err_code holds its value until the next error. err_count increments and saturates at 255.
- ctrl_enable=0 mid-packet (LEN/PAYLOAD/CSUM): abort to HUNT with no error. A held packet (HOLD) is kept and remains readable.
- rst mid-operation: everything returns to reset values next cycle, and any held packet is lost.

Decomposition:
- Package uart_pkt_pkg:
  - enum pkt_state_t {HUNT, LEN, PAYLOAD, CSUM, HOLD}
  - enum pkt_err_t {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT, ERR_OVERRUN}
  - constant for default SYNC_BYTE
- One sub-module, uart_pkt_timeout: clear/enable inputs, expire pulse output, parameter TIMEOUT_CYCLES.
- The payload buffer is an inferred register array inside the top.

Test Plan:
- Good packet: events A5,03,01,02,03,06 → pkt_valid=1, pkt_len=3, byte_data=01. Three byte_rd give 01,02,03, then pkt_valid=0 and state HUNT.
- Bad checksum: A5,02,10,20,31 → err_pulse once, err_code=2, err_count=1, pkt_valid stays 0. A following good packet is accepted.
- Bad length: A5,00 → err_code=1. A5,11 (MAX_LEN=16) → err_code=1, err_count=2.
- Timeout (TIMEOUT_CYCLES=50): A5,02,AA then 50 idle cycles → err_code=3, state HUNT. A later 55 byte is ignored.
- Overrun/release: hold a packet, send event 77 → err_code=4, payload intact. Final byte_rd coinciding with event A5 → no error, state LEN.
- Held rx_data_ready for 5 cycles counts as one byte. Reset asserted mid-PAYLOAD → all outputs return to reset values.
